tinker_program_loader: RTL and testbench

Boot-time program loader for the Tinker processor. It accepts a byte stream over a valid/ready handshake, packs little-endian 32-bit instruction words, and writes them into main memory starting at the processor's fetch origin 0x2000. It holds the processor in reset until the image is fully written and its checksum is verified. It is the memory writer paired with the processor's instruction-fetch reader.

---
 rtl/tinker_pkg.sv | 26 ++
 rtl/loader_byte_packer.sv | 44 ++++
 rtl/tinker_program_loader.sv | 145 ++++++++++++++
 tb/tb_tinker_program_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tinker_pkg.sv
// Shared definitions for the Tinker boot loader: load origin, memory size,
// image size bound and the loader state encoding.
// No logic; imported by the loader top and its byte packer.
package tinker_pkg;

    // Byte address of the first loaded word; equals the processor reset PC.
    localparam logic [63:0] LOAD_BASE = 64'h2000;

    // Main memory size in bytes.
    localparam logic [63:0] MEM_BYTES = 64'd524288;

    // Largest image, in 32-bit words, that fits between LOAD_BASE and the
    // top of memory (129024 at the defaults).
    localparam logic [31:0] MAX_WORDS = 32'((MEM_BYTES - LOAD_BASE) / 64'd4);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CSUM  = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } loader_state_e;

endpackage

// File: rtl/loader_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words (first byte -> [7:0]).
// Latency: word_dat/word_done are combinational on the 4th accepted byte.
// Backpressure: none internally; the caller only strobes byte_vld on accepted bytes.
// Ports: clock/rst, byte_vld + byte_dat in, word_dat (assembled word) and
//        word_done (4th byte of a word is being accepted this cycle) out.
module loader_byte_packer (
    input  logic        clock,
    input  logic        rst,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic [31:0] word_dat,
    output logic        word_done
);

    // Only the three older bytes need storage; the newest byte is taken
    // straight from the input when the word completes.
    logic [23:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;

    // New bytes enter at the top and shift down, so after four bytes the
    // first one sits in [7:0].
    assign word_dat  = {byte_dat, word_q};
    assign word_done = byte_vld && (cnt_q == 2'd3);

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (byte_vld) begin
            word_d = word_dat[31:8];
            cnt_d  = cnt_q + 2'd1;   // wraps to 0 after a full word
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/tinker_program_loader.sv
// Boot loader: byte stream (count, payload, XOR checksum) -> word writes at LOAD_BASE; holds CPU until verified.
// Latency: one WRITE cycle minimum per word after its 4th byte; done/error one cycle after the checksum byte.
// Backpressure: in_ready low while a write waits on wr_ready; wr_en/addr/data held until accepted.
// Ports: clock, rst (async active-low); in_valid/in_data/in_ready stream; wr_en/wr_addr/wr_data/wr_ready
//        memory write; cpu_hold, done, error status; words_loaded progress count.
module tinker_program_loader
    import tinker_pkg::*;
(
    input  logic        clock,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [63:0] wr_addr,
    output logic [31:0] wr_data,
    input  logic        wr_ready,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [31:0] words_loaded
);

    loader_state_e state_q, state_d;
    logic [31:0]   n_q, n_d;
    logic [7:0]    csum_q, csum_d;
    logic          wr_en_q, wr_en_d;
    logic [63:0]   wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic [31:0]   words_q, words_d;

    logic          byte_acc;
    logic          pack_vld;
    logic [31:0]   pack_word;
    logic          pack_done;

    // Ready depends only on the registered state, never on in_valid.
    assign in_ready = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);
    assign byte_acc = in_valid && in_ready;

    // Header and payload share one packer: both are whole words, so its
    // byte counter is naturally aligned when the header finishes.
    assign pack_vld = byte_acc && ((state_q == HDR) || (state_q == DATA));

    loader_byte_packer u_packer (
        .clock     (clock),
        .rst       (rst),
        .byte_vld  (pack_vld),
        .byte_dat  (in_data),
        .word_dat  (pack_word),
        .word_done (pack_done)
    );

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        csum_d    = csum_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        words_d   = words_q;
        cpu_hold  = 1'b1;
        done      = 1'b0;
        error     = 1'b0;

        case (state_q)
            BOOT: state_d = HDR;

            HDR: begin
                if (pack_done) begin
                    n_d = pack_word;
                    if (pack_word > MAX_WORDS) begin
                        state_d = ERROR;
                    end else if (pack_word == 32'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end

            DATA: begin
                if (byte_acc) begin
                    csum_d = csum_q ^ in_data;
                end
                if (pack_done) begin
                    // Register the write so it stays stable through stalls.
                    wr_en_d   = 1'b1;
                    wr_addr_d = LOAD_BASE + {30'd0, words_q, 2'b00};
                    wr_data_d = pack_word;
                    state_d   = WRITE;
                end
            end

            WRITE: begin
                if (wr_ready) begin
                    wr_en_d = 1'b0;
                    words_d = words_q + 32'd1;
                    state_d = ((words_q + 32'd1) == n_q) ? CSUM : DATA;
                end
            end

            CSUM: begin
                if (byte_acc) begin
                    state_d = (in_data == csum_q) ? DONE : ERROR;
                end
            end

            DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end

            ERROR: error = 1'b1;

            default: state_d = ERROR;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q   <= BOOT;
            n_q       <= '0;
            csum_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            words_q   <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            csum_q    <= csum_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            words_q   <= words_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_tinker_program_loader.sv
// Scoreboard bench for the program loader: expected writes queued by the
// stimulus, popped and compared by a monitor whenever the DUT presents a write.
// Status outputs are compared against hand-computed values after each load.
module tb_tinker_program_loader;

    logic        clock;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [31:0] words_loaded;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    wr_exp_t exp_q[$];
    int      checks;
    int      errors;
    int      stall_left;

    tinker_program_loader dut (
        .clock        (clock),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Memory side: accept immediately unless a stall budget is armed.
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            if (wr_en && stall_left > 0) begin
                wr_ready = 1'b0;
                stall_left--;
            end else begin
                wr_ready = 1'b1;
            end
        end
    end

    // Monitor: every presented write must match the head of the queue;
    // while stalled it must hold that value and keep the stream closed.
    always @(negedge clock) begin
        if (rst && wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
            end else begin
                chk("wr_addr", wr_addr, exp_q[0].addr);
                chk("wr_data", {32'd0, wr_data}, {32'd0, exp_q[0].data});
                chk("in_ready_during_write", {63'd0, in_ready}, 64'd0);
                if (wr_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 for byte %0h", b);
        end else begin
            @(posedge clock);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic push_w(input logic [63:0] a, input logic [31:0] d);
        wr_exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || error) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!(done || error)) begin
            checks++;
            errors++;
            $display("FAIL end_timeout: got done 0 error 0 expected one set");
        end
    endtask

    // {in_ready, wr_en, done, error, cpu_hold}
    task automatic chk_status(input string nm, input logic [4:0] exp_v);
        chk(nm, {59'd0, in_ready, wr_en, done, error, cpu_hold}, {59'd0, exp_v});
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst = 1'b0;
        #1;
        chk_status("reset_status", 5'b00001);
        chk("reset_wr_addr", wr_addr, 64'd0);
        chk("reset_wr_data", {32'd0, wr_data}, 64'd0);
        chk("reset_words", {32'd0, words_loaded}, 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        rst = 1'b1;
        #1;
        chk("boot_in_ready", {63'd0, in_ready}, 64'd0);
    endtask

    initial begin
        int n;
        checks     = 0;
        errors     = 0;
        stall_left = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        #2;

        // 1: single word, good checksum.
        do_reset();
        push_w(64'h2000, 32'h12345678);
        send_word(32'd1);
        send_word(32'h12345678);
        send_byte(8'h08);
        wait_end();
        chk_status("t1_status", 5'b00100);
        chk("t1_words", {32'd0, words_loaded}, 64'd1);

        // 2: two words, first write stalled three cycles.
        do_reset();
        stall_left = 3;
        push_w(64'h2000, 32'h11223344);
        push_w(64'h2004, 32'hAABBCCDD);
        send_word(32'd2);
        send_word(32'h11223344);
        send_word(32'hAABBCCDD);
        send_byte(8'h44);
        wait_end();
        chk_status("t2_status", 5'b00100);
        chk("t2_words", {32'd0, words_loaded}, 64'd2);
        chk("t2_stall_used", 64'(stall_left), 64'd0);

        // 3: bad checksum after a completed write.
        do_reset();
        push_w(64'h2000, 32'h12345678);
        send_word(32'd1);
        send_word(32'h12345678);
        send_byte(8'h09);
        wait_end();
        chk_status("t3_status", 5'b00011);
        chk("t3_words", {32'd0, words_loaded}, 64'd1);

        // 4: oversize header (129025 words) fails right after 4th byte.
        do_reset();
        send_word(32'd129025);
        chk_status("t4_status", 5'b00011);
        repeat (3) @(negedge clock);
        chk_status("t4_status_hold", 5'b00011);

        // Boundary: exactly MAX_WORDS is accepted and moves on to payload.
        do_reset();
        send_word(32'd129024);
        chk_status("max_words_status", 5'b10001);

        // 5: empty image.
        do_reset();
        send_word(32'd0);
        send_byte(8'h00);
        wait_end();
        chk_status("t5_status", 5'b00100);
        chk("t5_words", {32'd0, words_loaded}, 64'd0);

        // 6: reset in the middle of a 3-word load, then reload.
        do_reset();
        push_w(64'h2000, 32'h01020304);
        push_w(64'h2004, 32'h05060708);
        send_word(32'd3);
        send_word(32'h01020304);
        send_word(32'h05060708);
        n = 0;
        while (words_loaded != 32'd2 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("t6_words_before_reset", {32'd0, words_loaded}, 64'd2);
        chk("t6_queue_drained", 64'(exp_q.size()), 64'd0);
        do_reset();
        push_w(64'h2000, 32'hCAFEBABE);
        send_word(32'd1);
        send_word(32'hCAFEBABE);
        send_byte(8'h30);
        wait_end();
        chk_status("t6_status", 5'b00100);
        chk("t6_words", {32'd0, words_loaded}, 64'd1);

        repeat (3) @(negedge clock);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
